// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad receive path: FSM states,
// row/column geometry, the hex key map and a lowest-set-bit index helper.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  localparam logic [3:0] KEY_MAP [ROWS][COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic idx_t first_set(input logic [3:0] v);
    idx_t idx;
    logic found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        idx   = idx_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_decoder_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_row_decoder.sv
// Keypad row decoder: synchronizes rows against the scanned column, debounces
// press/release and emits a hex key code. KEYPAD_REPEAT_EN adds auto-repeat.
module keypad_row_decoder
  import keypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd2000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_onehot,
  input  logic [ROWS-1:0] rows_n,
  output logic [3:0]      key,
  output logic            key_valid,
  output logic            key_held
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic [ROWS-1:0]  arow_n;
  logic [COLS-1:0]  col_d1_q, col_d1_d, acol_q, acol_d;
  state_e           state_q, state_d;
  idx_t             lrow_q, lrow_d, lcol_q, lcol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             qualified, lcol_match, release_seen, press_seen, rpt_fire;

  sync_2ff #(
    .WIDTH     (ROWS),
    .RESET_VAL ('1)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows_n),
    .q     (arow_n)
  );

  // Only observations on the locked column can abort a debounce window.
  assign qualified    = $onehot(acol_q);
  assign lcol_match   = qualified && acol_q[lcol_q];
  assign release_seen = lcol_match && arow_n[lrow_q];
  assign press_seen   = lcol_match && !arow_n[lrow_q];
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 24'd1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Runs only while HELD persists; any other state or a release clears it.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (state_q == HELD && !release_seen) begin
      if (rpt_q == RPT_LAST) rpt_fire = 1'b1;
      else                   rpt_d    = rpt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
  if (REPEAT_CYCLES == '0) begin : g_no_repeat
  end
`endif

  always_comb begin
    col_d1_d    = col_onehot;
    acol_d      = col_d1_q;
    state_d     = state_q;
    lrow_d      = lrow_q;
    lcol_d      = lcol_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    unique case (state_q)
      IDLE: begin
        if (qualified && arow_n != '1) begin
          state_d = DEB_PRESS;
          lcol_d  = first_set(acol_q);
          lrow_d  = first_set(~arow_n);
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        cnt_d = cnt_inc;
        if (release_seen) begin
          state_d = IDLE;
        end else if (cnt_inc == CNT_LAST) begin
          state_d     = HELD;
          key_d       = KEY_MAP[lrow_q][lcol_q];
          key_valid_d = 1'b1;
        end
      end
      HELD: begin
        key_held_d = 1'b1;
        if (release_seen) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (rpt_fire) begin
          key_valid_d = 1'b1;
        end
      end
      DEB_RELEASE: begin
        cnt_d = cnt_inc;
        if (press_seen) begin
          state_d = HELD;
        end else if (cnt_inc == CNT_LAST) begin
          state_d    = IDLE;
          key_held_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_d1_q    <= '0;
      acol_q      <= '0;
      state_q     <= IDLE;
      lrow_q      <= '0;
      lcol_q      <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_d1_q    <= col_d1_d;
      acol_q      <= acol_d;
      state_q     <= state_d;
      lrow_q      <= lrow_d;
      lcol_q      <= lcol_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Directed bench for keypad_row_decoder: models the keypad as a pressed-key
// mask sampled against a column scanner that advances every 4 cycles.
module tb_keypad_row_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_onehot;
  logic [3:0] rows_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_row_decoder #(
    .DEBOUNCE_CYCLES (16'd8),
    .REPEAT_CYCLES   (24'd32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_onehot (col_onehot),
    .rows_n     (rows_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mask;       // bit r*4+c set = key at row r / col c pressed
  logic [3:0]  rows_idle;
  bit          scan_en;
  int          ci;
  int          phase;
  int          pq[$];
  logic [3:0]  kq[$];

  // One clock: drive scanner/keypad, record any key_valid pulse of this edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (scan_en) begin
      phase++;
      if (phase == 4) begin
        phase = 0;
        ci    = (ci + 1) % 4;
      end
      col_onehot = 4'(1 << ci);
      rows_n     = ~{mask[12+ci], mask[8+ci], mask[4+ci], mask[ci]};
    end else begin
      col_onehot = '0;
      rows_n     = rows_idle;
    end
    if (key_valid === 1'b1) begin
      pq.push_back(cyc);
      kq.push_back(key);
    end
  endtask

  task automatic step_until_before(input int c);
    int guard;
    guard = 0;
    while (!(phase == 3 && ci == (c + 3) % 4) && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) begin
      errors++;
      $display("FAIL scanner_align: got no alignment required col %0d", c);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    scan_en   = 1'b0;
    rows_idle = 4'b0000;
    mask      = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (key !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got key=%h v=%b h=%b required 0/0/0", key, key_valid, key_held);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL unqualified_rows: got v=%b h=%b required 0/0", key_valid, key_held);
      end
    end
    rows_idle = 4'b1111;
    scan_en   = 1'b1;
    ci        = 3;
    phase     = 3;
    repeat (20) step();
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL idle_no_pulse: got %0d pulses required 0", pq.size());
    end
  endtask

  task automatic test_clean_press();
    int n, r;
    pq.delete(); kq.delete();
    step_until_before(2);
    mask = 16'h1 << 6;
    step();
    n = cyc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cyc == n + 10) begin
        checks++;
        if (key_held !== 1'b0) begin
          errors++;
          $display("FAIL held_on_pulse_cycle: got %b required 0", key_held);
        end
      end
      if (cyc == n + 11) begin
        checks++;
        if (key_held !== 1'b1) begin
          errors++;
          $display("FAIL held_after_pulse: got %b required 1", key_held);
        end
      end
    end
    checks++;
    if (pq.size() != 1) begin
      errors++;
      $display("FAIL clean_pulse_count: got %0d required 1", pq.size());
    end else begin
      checks += 2;
      if (pq[0] != n + 10) begin
        errors++;
        $display("FAIL clean_latency: got cycle %0d required %0d", pq[0], n + 10);
      end
      if (kq[0] !== 4'h6) begin
        errors++;
        $display("FAIL clean_key: got %h required 6", kq[0]);
      end
    end
    step_until_before(2);
    mask = '0;
    step();
    r = cyc;
    while (cyc < r + 12) begin
      step();
      checks++;
      if (key_held !== (cyc < r + 10)) begin
        errors++;
        $display("FAIL clean_release_held: cycle +%0d got %b required %b", cyc - r, key_held, cyc < r + 10);
      end
    end
    checks += 2;
    if (key !== 4'h6) begin
      errors++;
      $display("FAIL clean_key_retained: got %h required 6", key);
    end
    if (pq.size() != 1) begin
      errors++;
      $display("FAIL clean_release_pulses: got %0d required 1", pq.size());
    end
  endtask

  task automatic test_bounce();
    int n0;
    pq.delete(); kq.delete();
    step_until_before(0);
    mask = 16'h1;
    step();
    n0 = cyc;
    step(); step();
    mask = '0;
    step(); step();
    mask = 16'h1;
    while (cyc < n0 + 40) step();
    checks++;
    if (pq.size() != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count: got %0d required 1", pq.size());
    end else begin
      checks += 2;
      if (pq[0] != n0 + 26) begin
        errors++;
        $display("FAIL bounce_latency: got cycle %0d required %0d", pq[0], n0 + 26);
      end
      if (kq[0] !== 4'h1) begin
        errors++;
        $display("FAIL bounce_key: got %h required 1", kq[0]);
      end
    end
    mask = '0;
    repeat (40) step();
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL bounce_release: got held=%b required 0", key_held);
    end
  endtask

  task automatic test_second_key();
    int n, r;
    pq.delete(); kq.delete();
    step_until_before(1);
    mask = 16'h1 << 5;
    step();
    n = cyc;
    repeat (20) step();
    mask = mask | (16'h1 << 10);
    repeat (40) step();
    checks += 3;
    if (pq.size() != 1 || pq[0] != n + 10) begin
      errors++;
      $display("FAIL second_key_ignored: got %0d pulses required 1 at +10", pq.size());
    end
    if (key !== 4'h5) begin
      errors++;
      $display("FAIL second_key_code: got %h required 5", key);
    end
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL second_key_held: got %b required 1", key_held);
    end
    step_until_before(1);
    mask = 16'h1 << 10;
    step();
    r = cyc;
    while (cyc < r + 29) step();
    checks += 2;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL second_release_held: got %b required 0", key_held);
    end
    if (pq.size() != 1) begin
      errors++;
      $display("FAIL no_pulse_before_fresh: got %0d pulses required 1", pq.size());
    end
    while (cyc < r + 35) step();
    checks++;
    if (pq.size() != 2) begin
      errors++;
      $display("FAIL fresh_nine_count: got %0d pulses required 2", pq.size());
    end else begin
      checks += 2;
      if (pq[1] != r + 30) begin
        errors++;
        $display("FAIL fresh_nine_latency: got cycle %0d required %0d", pq[1], r + 30);
      end
      if (kq[1] !== 4'h9) begin
        errors++;
        $display("FAIL fresh_nine_key: got %h required 9", kq[1]);
      end
    end
    mask = '0;
    repeat (40) step();
    checks++;
    if (key_held !== 1'b0 || key !== 4'h9) begin
      errors++;
      $display("FAIL nine_release: got held=%b key=%h required 0/9", key_held, key);
    end
  endtask

  task automatic test_release_bounce();
    int n, r;
    pq.delete(); kq.delete();
    step_until_before(1);
    mask = 16'h1 << 13;
    step();
    n = cyc;
    repeat (24) step();
    checks++;
    if (pq.size() != 1 || kq[0] !== 4'h0 || pq[0] != n + 10) begin
      errors++;
      $display("FAIL rb_accept: got %0d pulses required 1 of key 0 at +10", pq.size());
    end
    step_until_before(1);
    mask = '0;
    step();
    r = cyc;
    step();
    mask = 16'h1 << 13;
    step(); step();
    mask = '0;
    while (cyc < r + 28) begin
      step();
      checks++;
      if (key_held !== (cyc < r + 26)) begin
        errors++;
        $display("FAIL rb_held: cycle +%0d got %b required %b", cyc - r, key_held, cyc < r + 26);
      end
    end
    checks += 2;
    if (key !== 4'h0) begin
      errors++;
      $display("FAIL rb_key_retained: got %h required 0", key);
    end
    if (pq.size() != 1) begin
      errors++;
      $display("FAIL rb_no_extra_pulse: got %0d required 1", pq.size());
    end
  endtask

  task automatic test_reset_mid_debounce();
    pq.delete(); kq.delete();
    step_until_before(1);
    mask = 16'h1 << 1;
    step();
    repeat (4) step();
    reset = 1'b1;
    mask  = '0;
    step();
    reset = 1'b0;
    repeat (30) step();
    checks += 2;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL reset_abort_pulse: got %0d pulses required 0", pq.size());
    end
    if (key !== 4'h0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_state: got key=%h held=%b required 0/0", key, key_held);
    end
  endtask

  task automatic test_repeat();
    int n, exp_cnt;
`ifdef KEYPAD_REPEAT_EN
    exp_cnt = 4;
`else
    exp_cnt = 1;
`endif
    pq.delete(); kq.delete();
    step_until_before(3);
    mask = 16'h1 << 15;
    step();
    n = cyc;
    while (cyc < n + 112) step();
    checks++;
    if (pq.size() != exp_cnt) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses required %0d", pq.size(), exp_cnt);
    end
    for (int i = 0; i < pq.size(); i++) begin
      checks += 2;
      if (pq[i] != n + 10 + 32 * i) begin
        errors++;
        $display("FAIL repeat_timing: pulse %0d got cycle %0d required %0d", i, pq[i], n + 10 + 32 * i);
      end
      if (kq[i] !== 4'hD) begin
        errors++;
        $display("FAIL repeat_key: pulse %0d got %h required D", i, kq[i]);
      end
    end
    mask = '0;
    repeat (40) step();
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL repeat_release: got held=%b required 0", key_held);
    end
  endtask

  initial begin
    reset      = 1'b1;
    col_onehot = '0;
    rows_n     = '0;
    mask       = '0;
    rows_idle  = '0;
    scan_en    = 1'b0;
    ci         = 3;
    phase      = 3;
    test_reset();
    test_clean_press();
    test_bounce();
    test_second_key();
    test_release_bounce();
    test_reset_mid_debounce();
    test_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
